// File: rtl/mult_unit_if.sv
// Start/ready handshake plus HI/LO access between the pipeline (master) and the multiplier (slave).
// The master holds off new requests while ready is low.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b, hi_we, lo_we, wdata,
    input  ready, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b, hi_we, lo_we, wdata,
    output ready, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Shift-add MULT/MULTU unit with HI/LO registers; result WIDTH+1 cycles after start.
// ready is low while busy: start and MTHI/MTLO writes are ignored until FINISH.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               neg, neg_nxt;
  logic               done_q, done_nxt;
  logic [WIDTH-1:0]   hi_q, hi_nxt;
  logic [WIDTH-1:0]   lo_q, lo_nxt;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] result;

  // Negating the most negative value wraps back to itself, which is its correct unsigned magnitude.
  assign a_mag     = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
  assign result    = neg ? -acc : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      neg    <= neg_nxt;
      done_q <= done_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    neg_nxt    = neg;
    done_nxt   = 1'b0;
    hi_nxt     = hi_q;
    lo_nxt     = lo_q;
    case (state)
      IDLE: begin
        if (bus.hi_we) hi_nxt = bus.wdata;
        if (bus.lo_we) lo_nxt = bus.wdata;
        if (bus.start) begin
          mcand_nxt  = a_mag;
          mplier_nxt = b_mag;
          neg_nxt    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_nxt    = '0;
          cnt_nxt    = '0;
        end
      end
      RUN: begin
        acc_nxt    = {upper_sum, acc[WIDTH-1:1]};
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CW'(1);
      end
      FINISH: begin
        hi_nxt   = result[2*WIDTH-1:WIDTH];
        lo_nxt   = result[WIDTH-1:0];
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: products, latency, done pulse, MTHI/MTLO and reset abort.
module tb_mult_unit;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mult_unit_if #(.WIDTH(32)) bus ();
  mult_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
    bus.start = 1'b1; bus.is_signed = sgn; bus.a = av; bus.b = bv;
    tick();
    bus.start = 1'b0; bus.a = 32'h0; bus.b = 32'h0; bus.is_signed = 1'b0;
  endtask

  task automatic wait_ready(output int cyc, output int dpulses);
    cyc = 0; dpulses = 0;
    while (!bus.ready && cyc < 200) begin
      tick();
      cyc++;
      if (bus.done) dpulses++;
    end
  endtask

  task automatic finish_mult(input string tag, input logic [31:0] eh, input logic [31:0] el);
    int cyc, dp;
    wait_ready(cyc, dp);
    check({tag, "_lat"}, 64'(cyc), 64'd33);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_npulse"}, 64'(dp), 64'd1);
    check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    check({tag, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  initial begin
    int cyc, dp;
    reset = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done",  64'(bus.done),  64'd0);
    check("rst_hi",    64'(bus.hi),    64'd0);
    check("rst_lo",    64'(bus.lo),    64'd0);

    // 1: MULTU 3*5
    launch(1'b0, 32'd3, 32'd5);
    check("t1_busy", 64'(bus.ready), 64'd0);
    finish_mult("t1", 32'h0, 32'hF);
    tick();
    check("t1_done_drop", 64'(bus.done), 64'd0);

    // 2: MULT -1*2 then back-to-back MULTU of the same operands
    launch(1'b1, 32'hFFFFFFFF, 32'd2);
    finish_mult("t2s", 32'hFFFFFFFF, 32'hFFFFFFFE);
    launch(1'b0, 32'hFFFFFFFF, 32'd2);
    check("t2_b2b_busy", 64'(bus.ready), 64'd0);
    check("t2_b2b_done", 64'(bus.done), 64'd0);
    check("t2_hold_hi", 64'(bus.hi), 64'hFFFFFFFF);
    finish_mult("t2u", 32'h1, 32'hFFFFFFFE);
    tick();

    // 3: extremes
    launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish_mult("t3u", 32'hFFFFFFFE, 32'h1);
    tick();
    launch(1'b1, 32'h80000000, 32'h80000000);
    finish_mult("t3s", 32'h40000000, 32'h0);
    tick();

    // 4: start and MTHI during RUN are dropped
    launch(1'b0, 32'd7, 32'd9);
    repeat (9) tick();
    bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    tick();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.hi_we = 1'b0;
    check("t4_hi_kept", 64'(bus.hi), 64'h40000000);
    wait_ready(cyc, dp);
    check("t4_lat", 64'(cyc), 64'd23);
    check("t4_npulse", 64'(dp), 64'd1);
    check("t4_hi", 64'(bus.hi), 64'd0);
    check("t4_lo", 64'(bus.lo), 64'd63);
    tick();
    check("t4_no_extra", 64'(bus.done), 64'd0);
    check("t4_idle", 64'(bus.ready), 64'd1);

    // 5: MTHI / MTLO in IDLE
    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h9ABCDEF0;
    tick();
    bus.lo_we = 1'b0;
    check("t5_hi", 64'(bus.hi), 64'h12345678);
    check("t5_lo", 64'(bus.lo), 64'h9ABCDEF0);
    check("t5_done", 64'(bus.done), 64'd0);
    check("t5_ready", 64'(bus.ready), 64'd1);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h00C0FFEE;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("t5_both_hi", 64'(bus.hi), 64'h00C0FFEE);
    check("t5_both_lo", 64'(bus.lo), 64'h00C0FFEE);

    // start with a simultaneous MTLO: write lands, then the product overwrites it
    bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
    launch(1'b0, 32'd100, 32'd200);
    bus.lo_we = 1'b0;
    check("t5_sw_lo", 64'(bus.lo), 64'hA5A5A5A5);
    finish_mult("t5_sw", 32'h0, 32'd20000);
    tick();

    // 6: reset aborts an in-flight multiply
    launch(1'b1, 32'hFFFFFFFA, 32'd7);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_ready", 64'(bus.ready), 64'd1);
    check("t6_hi", 64'(bus.hi), 64'd0);
    check("t6_lo", 64'(bus.lo), 64'd0);
    check("t6_done", 64'(bus.done), 64'd0);
    dp = 0;
    repeat (40) begin
      tick();
      if (bus.done) dp++;
    end
    check("t6_no_done", 64'(dp), 64'd0);
    launch(1'b1, 32'hFFFFFFFA, 32'd7);
    finish_mult("t6", 32'hFFFFFFFF, 32'hFFFFFFD6);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
